// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin scheduler sharing one AES-128 core among NUM_REQ requesters.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           per-requester job handshake (req_ready one-hot or zero)
//   req_enc_dec/req_data/req_key  per-requester job fields, requester i at [i] / [i*128+:128]
//   rsp_valid/rsp_ready           shared response handshake
//   rsp_id/rsp_data/rsp_timeout   response tag, result block, watchdog-error flag
//   core_start                    single-cycle start pulse to the core
//   core_enc_dec/core_data_in/core_key_in  core inputs, held stable for the whole job
//   core_data_out/core_ready      core result and done flag
//   busy                          high whenever not IDLE
//   fault                         sticky watchdog fault, cleared only by rst_n
module aes_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_enc_dec,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_data,
    output logic                   rsp_timeout,
    output logic                   core_start,
    output logic                   core_enc_dec,
    output logic [127:0]           core_data_in,
    output logic [127:0]           core_key_in,
    input  logic [127:0]           core_data_out,
    input  logic                   core_ready,
    output logic                   busy,
    output logic                   fault
);
    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, FAULT} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, gnt_id;
    logic [CNT_W-1:0]   wd;
    logic [NUM_REQ-1:0] hi_mask, pick, oh;
    logic [ID_W-1:0]    id_acc   [NUM_REQ+1];
    logic [127:0]       data_acc [NUM_REQ+1];
    logic [127:0]       key_acc  [NUM_REQ+1];
    logic               grant, wd_expire, sel_enc;
    // Requests at or after the pointer win; if none, wrap to the lowest valid index.
    // The one-hot winner drives AND-OR muxes so no variable indexing is needed.
    assign id_acc[0]   = '0;
    assign data_acc[0] = '0;
    assign key_acc[0]  = '0;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
        assign hi_mask[g]    = req_valid[g] & (g >= int'(ptr));
        assign id_acc[g+1]   = id_acc[g] | (oh[g] ? ID_W'(g) : '0);
        assign data_acc[g+1] = data_acc[g] | ({128{oh[g]}} & req_data[g*128 +: 128]);
        assign key_acc[g+1]  = key_acc[g] | ({128{oh[g]}} & req_key[g*128 +: 128]);
    end
    assign pick      = (|hi_mask) ? hi_mask : req_valid;
    assign oh        = pick & (-pick);
    assign gnt_id    = id_acc[NUM_REQ];
    assign sel_enc   = |(oh & req_enc_dec);
    // A still-asserted core_ready means the previous result has not been cleared yet.
    assign grant     = (state == IDLE) && (|req_valid) && !core_ready;
    assign req_ready = grant ? oh : '0;
    // Compare-based wrap keeps non-power-of-2 requester counts correct.
    assign ptr_nxt   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    assign wd_expire = (wd == CNT_W'(TIMEOUT_CYCLES-1));
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? START : IDLE;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = (core_ready || wd_expire) ? RESP : WAIT;
            RESP:    state_nxt = !rsp_ready ? RESP : (fault ? FAULT : IDLE);
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end
    // core_start is a flop rather than a state decode so it can never glitch high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            wd           <= '0;
            core_start   <= 1'b0;
            core_enc_dec <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_start <= grant;
            wd         <= (state == WAIT) ? wd + CNT_W'(1) : '0;
            if (grant) begin
                ptr          <= ptr_nxt;
                rsp_id       <= gnt_id;
                core_enc_dec <= sel_enc;
                core_data_in <= data_acc[NUM_REQ];
                core_key_in  <= key_acc[NUM_REQ];
            end
            if (state == WAIT && core_ready) begin
                rsp_data    <= core_data_out;
                rsp_timeout <= 1'b0;
            end else if (state == WAIT && wd_expire) begin
                rsp_data    <= '0;
                rsp_timeout <= 1'b1;
                fault       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: table-driven and scoreboard bench for aes_req_arbiter with a stub AES core.
module tb_aes_req_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;
    localparam int TO = 16;
    localparam int CW = 8;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    typedef struct { logic [IW-1:0] id; logic [127:0] data; logic to; } exp_t;
    typedef struct { int id; logic enc; logic [127:0] data; logic [127:0] key; logic [127:0] exp; } vec_t;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [N-1:0] req_valid, req_ready, req_enc_dec;
    logic [N*128-1:0] req_data, req_key;
    logic rsp_valid, rsp_ready, rsp_timeout, core_start, core_enc_dec, core_ready, busy, fault;
    logic [IW-1:0] rsp_id;
    logic [127:0] rsp_data, core_data_in, core_key_in, core_data_out;
    exp_t sb[$];
    exp_t e;
    vec_t tbl[4];
    int n_chk = 0, n_err = 0, cyc = 0, start_cyc = 0, lat = 4, st_cnt = 0, st_hold = 0;
    logic hang = 1'b0, prev_start = 1'b0, st_run = 1'b0, st_e = 1'b0;
    logic [127:0] st_d = '0, st_k = '0;

    aes_req_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_enc_dec(req_enc_dec), .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .core_start(core_start), .core_enc_dec(core_enc_dec),
        .core_data_in(core_data_in), .core_key_in(core_key_in), .core_data_out(core_data_out),
        .core_ready(core_ready), .busy(busy), .fault(fault));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: known FIPS-197 vectors return their true results, anything else a simple mix.
    function automatic logic [127:0] aes_model(input logic enc, input logic [127:0] d, input logic [127:0] k);
        if (enc && d == P1 && k == K1) return C1;
        if (!enc && d == C2 && k == K2) return P2;
        return {d[63:0], d[127:64]} ^ k ^ {128{enc}};
    endfunction

    // Result appears lat cycles after start and core_ready stays high for 4 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready    <= 1'b0;
            core_data_out <= '0;
            st_run        <= 1'b0;
            st_cnt        <= 0;
            st_hold       <= 0;
        end else if (core_start && !hang) begin
            st_run <= 1'b1;
            st_cnt <= lat;
            st_d   <= core_data_in;
            st_k   <= core_key_in;
            st_e   <= core_enc_dec;
        end else if (st_run) begin
            if (st_cnt <= 1) begin
                st_run        <= 1'b0;
                core_ready    <= 1'b1;
                core_data_out <= aes_model(st_e, st_d, st_k);
                st_hold       <= 4;
            end else st_cnt <= st_cnt - 1;
        end else if (core_ready) begin
            if (st_hold <= 1) core_ready <= 1'b0;
            st_hold <= st_hold - 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: start legality, grant shape, and scoreboard pops on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) begin
                start_cyc = cyc;
                chk("start_legal", {core_ready, rsp_valid, prev_start}, '0);
            end
            if (req_ready != '0) chk("ready_onehot", $onehot(req_ready), 1);
            if (!busy && core_ready && req_valid != '0) chk("no_grant_core_ready", req_ready, '0);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) fail("unexpected_rsp");
                else begin
                    e = sb.pop_front();
                    chk("rsp", {rsp_id, rsp_timeout, rsp_data}, {e.id, e.to, e.data});
                end
            end
        end
        prev_start = core_start;
    end

    task automatic send(input int i, input logic enc, input logic [127:0] d, input logic [127:0] k);
        req_enc_dec[i] = enc;
        req_data[i*128 +: 128] = d;
        req_key[i*128 +: 128] = k;
        req_valid[i] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1 req_valid[i] = 1'b0;
                return;
            end
        end
        fail("accept");
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("drain");
        sb.delete();
    endtask

    task automatic wait_rsp(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        fail("wait_rsp");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, rsp_valid, core_start, req_ready, core_enc_dec, fault, rsp_id, rsp_timeout}, '0);
        chk({tag, "_core"}, {core_data_in, core_key_in}, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        req_valid = '0;
        req_enc_dec = '0;
        req_data = '0;
        req_key = '0;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tbl[0] = '{0, 1'b1, P1, K1, C1};
        tbl[1] = '{1, 1'b0, C2, K2, P2};
        tbl[2] = '{0, 1'b0, 128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h1, '0};
        tbl[3] = '{1, 1'b1, 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0, 128'h55aa, '0};
        for (int v = 2; v < 4; v++) tbl[v].exp = aes_model(tbl[v].enc, tbl[v].data, tbl[v].key);
        for (int v = 0; v < 4; v++) begin
            sb.push_back('{IW'(tbl[v].id), tbl[v].exp, 1'b0});
            send(tbl[v].id, tbl[v].enc, tbl[v].data, tbl[v].key);
            drain(100);
        end
        // Both requesters continuously valid: grants must alternate 0,1,0,1.
        sb.push_back('{IW'(0), aes_model(1'b1, 128'hA, 128'h1A), 1'b0});
        sb.push_back('{IW'(1), aes_model(1'b0, 128'hB, 128'h1B), 1'b0});
        sb.push_back('{IW'(0), aes_model(1'b0, 128'hC, 128'h1C), 1'b0});
        sb.push_back('{IW'(1), aes_model(1'b1, 128'hD, 128'h1D), 1'b0});
        fork
            begin send(0, 1'b1, 128'hA, 128'h1A); send(0, 1'b0, 128'hC, 128'h1C); end
            begin send(1, 1'b0, 128'hB, 128'h1B); send(1, 1'b1, 128'hD, 128'h1D); end
        join
        drain(200);
        // Response back-pressure with a competing request pending.
        rsp_ready = 1'b0;
        sb.push_back('{IW'(0), aes_model(1'b1, 128'hE, 128'h1E), 1'b0});
        sb.push_back('{IW'(1), aes_model(1'b1, 128'hF, 128'h1F), 1'b0});
        send(0, 1'b1, 128'hE, 128'h1E);
        fork send(1, 1'b1, 128'hF, 128'h1F); join_none
        wait_rsp(100);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold", {rsp_valid, rsp_id, rsp_data, req_ready, core_start},
                {1'b1, IW'(0), aes_model(1'b1, 128'hE, 128'h1E), 2'b00, 1'b0});
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain(200);
        // Reset during WAIT aborts the job; the pointer returns to requester 0.
        lat = 12;
        send(0, 1'b1, 128'h6, 128'h16);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, '0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat = 4;
        sb.push_back('{IW'(0), aes_model(1'b0, 128'h7, 128'h17), 1'b0});
        sb.push_back('{IW'(1), aes_model(1'b1, 128'h8, 128'h18), 1'b0});
        fork
            send(0, 1'b0, 128'h7, 128'h17);
            send(1, 1'b1, 128'h8, 128'h18);
        join
        drain(200);
        // Hung core: timeout response 17 cycles after start, then sticky fault.
        hang = 1'b1;
        sb.push_back('{IW'(1), '0, 1'b1});
        send(1, 1'b1, 128'h9, 128'h19);
        wait_rsp(100);
        chk("timeout_latency", cyc - start_cyc, 17);
        req_enc_dec[0] = 1'b1;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("fault_hold", {fault, busy, req_ready, core_start, rsp_valid}, {1'b1, 1'b1, 2'b00, 1'b0, 1'b0});
        end
        chk("sb_empty", sb.size(), 0);
        req_valid = '0;
        hang = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("fault_reset");
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
